// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer: drives the Stage code and NOP_FLAG for the
// stage-enable decoder, with free-run, single-step, sticky halt and a retire counter.
module stage_sequencer #(
    parameter int unsigned                 OPCODE_WIDTH = 4,
    parameter logic [OPCODE_WIDTH-1:0]     NOP_OPCODE   = '0,
    parameter int unsigned                 ICOUNT_WIDTH = 16
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    Run,
    input  logic                    Step,
    input  logic                    Halt_Req,
    input  logic [OPCODE_WIDTH-1:0] Opcode_In,
    output logic [2:0]              Stage,
    output logic                    NOP_FLAG,
    output logic                    Running,
    output logic                    Halted,
    output logic                    Instr_Done,
    output logic [ICOUNT_WIDTH-1:0] Instr_Count
);

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_RUN,
        MODE_STEP,
        MODE_HALTED
    } mode_t;

    typedef enum logic [2:0] {
        ST_NONE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5
    } stage_t;

    localparam logic [ICOUNT_WIDTH-1:0] ICOUNT_ONE = {{(ICOUNT_WIDTH-1){1'b0}}, 1'b1};

    stage_t                  stage_q;
    mode_t                   mode_q;
    logic                    halt_latch;
    logic                    nop_latch;
    logic [ICOUNT_WIDTH-1:0] icount_q;
    logic                    is_nop;

    assign is_nop = (Opcode_In == NOP_OPCODE);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            stage_q    <= ST_NONE;
            mode_q     <= MODE_IDLE;
            halt_latch <= 1'b0;
            nop_latch  <= 1'b0;
            icount_q   <= '0;
        end else begin
            if (stage_q != ST_NONE && Halt_Req)
                halt_latch <= 1'b1;

            case (stage_q)
                ST_NONE: begin
                    if (mode_q != MODE_HALTED) begin
                        if (Halt_Req) begin
                            mode_q <= MODE_HALTED;
                        end else if (Run) begin
                            stage_q <= ST_FETCH;
                            mode_q  <= MODE_RUN;
                        end else if (Step) begin
                            stage_q <= ST_FETCH;
                            mode_q  <= MODE_STEP;
                        end else begin
                            mode_q <= MODE_IDLE;
                        end
                    end
                end
                ST_FETCH:   stage_q <= ST_DECODE;
                ST_DECODE: begin
                    stage_q   <= ST_EXECUTE;
                    nop_latch <= is_nop;
                end
                ST_EXECUTE: stage_q <= ST_MEMORY;
                ST_MEMORY:  stage_q <= ST_WRITEBACK;
                ST_WRITEBACK: begin
                    icount_q <= icount_q + ICOUNT_ONE;
                    // A halt request on this very edge still wins over back-to-back run.
                    if (halt_latch || Halt_Req) begin
                        stage_q <= ST_NONE;
                        mode_q  <= MODE_HALTED;
                    end else if (mode_q == MODE_RUN && Run) begin
                        stage_q <= ST_FETCH;
                    end else begin
                        stage_q <= ST_NONE;
                        mode_q  <= MODE_IDLE;
                    end
                end
                default: begin
                    stage_q <= ST_NONE;
                    mode_q  <= MODE_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        NOP_FLAG = 1'b0;
        case (stage_q)
            ST_DECODE:                          NOP_FLAG = is_nop;
            ST_EXECUTE, ST_MEMORY, ST_WRITEBACK: NOP_FLAG = nop_latch;
            default:                            NOP_FLAG = 1'b0;
        endcase
    end

    assign Stage       = stage_q;
    assign Running     = (stage_q != ST_NONE);
    assign Instr_Done  = (stage_q == ST_WRITEBACK);
    assign Halted      = (mode_q == MODE_HALTED);
    assign Instr_Count = icount_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-cycle vector table through a scoreboard queue,
// plus hand-written async-reset and counter-wrap sequences.
module tb_stage_sequencer;

    typedef struct {
        logic        run;
        logic        step;
        logic        halt;
        logic [3:0]  op;
        logic [2:0]  stage;
        logic        nop;
        logic        halted;
        logic [15:0] cnt;
    } vec_t;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic        Step;
    logic        Halt_Req;
    logic [3:0]  Opcode_In;
    logic [2:0]  Stage,  stage_w;
    logic        NOP_FLAG, nop_w;
    logic        Running, running_w;
    logic        Halted, halted_w;
    logic        Instr_Done, done_w;
    logic [15:0] Instr_Count;
    logic [3:0]  cnt_w;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    vec_t        tbl[$];
    vec_t        sb_q[$];

    stage_sequencer #(.OPCODE_WIDTH(4), .NOP_OPCODE(4'b0000), .ICOUNT_WIDTH(16)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Step(Step), .Halt_Req(Halt_Req),
        .Opcode_In(Opcode_In), .Stage(Stage), .NOP_FLAG(NOP_FLAG), .Running(Running),
        .Halted(Halted), .Instr_Done(Instr_Done), .Instr_Count(Instr_Count)
    );

    // Narrow counter instance sharing all stimulus, so wrap-around is reachable quickly.
    stage_sequencer #(.OPCODE_WIDTH(4), .NOP_OPCODE(4'b0000), .ICOUNT_WIDTH(4)) dut_w (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Step(Step), .Halt_Req(Halt_Req),
        .Opcode_In(Opcode_In), .Stage(stage_w), .NOP_FLAG(nop_w), .Running(running_w),
        .Halted(halted_w), .Instr_Done(done_w), .Instr_Count(cnt_w)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic r, input logic s, input logic h, input logic [3:0] op,
                                input logic [2:0] st, input logic nop, input logic hl,
                                input logic [15:0] cnt);
        vec_t v;
        v.run = r; v.step = s; v.halt = h; v.op = op;
        v.stage = st; v.nop = nop; v.halted = hl; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs(input vec_t e);
        chk("stage",      32'(Stage),       32'(e.stage));
        chk("nop_flag",   32'(NOP_FLAG),    32'(e.nop));
        chk("running",    32'(Running),     32'(e.stage != 3'd0));
        chk("instr_done", 32'(Instr_Done),  32'(e.stage == 3'd5));
        chk("halted",     32'(Halted),      32'(e.halted));
        chk("count",      32'(Instr_Count), 32'(e.cnt));
        chk("count_w4",   32'(cnt_w),       32'(e.cnt[3:0]));
    endtask

    // Inputs for a cycle are driven just after the rising edge; that cycle's
    // expected outputs are checked on the falling edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge Clock);
        #1;
        Run = v.run; Step = v.step; Halt_Req = v.halt; Opcode_In = v.op;
        sb_q.push_back(v);
        @(negedge Clock);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_outputs(e);
        end
        cyc++;
    endtask

    task automatic check_reset_now();
        chk("rst_stage",   32'(Stage),       32'd0);
        chk("rst_nop",     32'(NOP_FLAG),    32'd0);
        chk("rst_running", 32'(Running),     32'd0);
        chk("rst_done",    32'(Instr_Done),  32'd0);
        chk("rst_halted",  32'(Halted),      32'd0);
        chk("rst_count",   32'(Instr_Count), 32'd0);
        chk("rst_count_w", 32'(cnt_w),       32'd0);
    endtask

    initial begin
        // free-run 12 cycles, then let the third instruction drain
        tbl.push_back(mk(1,0,0,4'h3, 0,0,0, 0));
        tbl.push_back(mk(1,0,0,4'h3, 1,0,0, 0));
        tbl.push_back(mk(1,0,0,4'h3, 2,0,0, 0));
        tbl.push_back(mk(1,0,0,4'h3, 3,0,0, 0));
        tbl.push_back(mk(1,0,0,4'h3, 4,0,0, 0));
        tbl.push_back(mk(1,0,0,4'h3, 5,0,0, 0));
        tbl.push_back(mk(1,0,0,4'h3, 1,0,0, 1));
        tbl.push_back(mk(1,0,0,4'h3, 2,0,0, 1));
        tbl.push_back(mk(1,0,0,4'h3, 3,0,0, 1));
        tbl.push_back(mk(1,0,0,4'h3, 4,0,0, 1));
        tbl.push_back(mk(1,0,0,4'h3, 5,0,0, 1));
        tbl.push_back(mk(1,0,0,4'h3, 1,0,0, 2));
        tbl.push_back(mk(0,0,0,4'h3, 2,0,0, 2));
        tbl.push_back(mk(0,0,0,4'h3, 3,0,0, 2));
        tbl.push_back(mk(0,0,0,4'h3, 4,0,0, 2));
        tbl.push_back(mk(0,0,0,4'h3, 5,0,0, 2));
        tbl.push_back(mk(0,0,0,4'h3, 0,0,0, 3));
        // single step; second pulse in stage 3 ignored
        tbl.push_back(mk(0,1,0,4'h3, 0,0,0, 3));
        tbl.push_back(mk(0,0,0,4'h3, 1,0,0, 3));
        tbl.push_back(mk(0,0,0,4'h3, 2,0,0, 3));
        tbl.push_back(mk(0,1,0,4'h3, 3,0,0, 3));
        tbl.push_back(mk(0,0,0,4'h3, 4,0,0, 3));
        tbl.push_back(mk(0,0,0,4'h3, 5,0,0, 3));
        tbl.push_back(mk(0,0,0,4'h3, 0,0,0, 4));
        tbl.push_back(mk(0,0,0,4'h3, 0,0,0, 4));
        tbl.push_back(mk(0,0,0,4'h3, 0,0,0, 4));
        // NOP latched in stage 2, opcode changes from stage 3 on
        tbl.push_back(mk(1,0,0,4'h3, 0,0,0, 4));
        tbl.push_back(mk(1,0,0,4'h0, 1,0,0, 4));
        tbl.push_back(mk(1,0,0,4'h0, 2,1,0, 4));
        tbl.push_back(mk(1,0,0,4'h3, 3,1,0, 4));
        tbl.push_back(mk(1,0,0,4'h3, 4,1,0, 4));
        tbl.push_back(mk(1,0,0,4'h3, 5,1,0, 4));
        tbl.push_back(mk(1,0,0,4'h3, 1,0,0, 5));
        tbl.push_back(mk(1,0,0,4'h3, 2,0,0, 5));
        tbl.push_back(mk(1,0,0,4'h3, 3,0,0, 5));
        tbl.push_back(mk(0,0,0,4'h3, 4,0,0, 5));
        tbl.push_back(mk(0,0,0,4'h3, 5,0,0, 5));
        tbl.push_back(mk(0,0,0,4'h3, 0,0,0, 6));
        // halt requested in stage 2, Run dropped in stage 4
        tbl.push_back(mk(1,0,0,4'h3, 0,0,0, 6));
        tbl.push_back(mk(1,0,0,4'h3, 1,0,0, 6));
        tbl.push_back(mk(1,0,1,4'h3, 2,0,0, 6));
        tbl.push_back(mk(1,0,0,4'h3, 3,0,0, 6));
        tbl.push_back(mk(0,0,0,4'h3, 4,0,0, 6));
        tbl.push_back(mk(0,0,0,4'h3, 5,0,0, 6));
        tbl.push_back(mk(0,0,0,4'h3, 0,0,1, 7));
        tbl.push_back(mk(1,0,0,4'h3, 0,0,1, 7));
        tbl.push_back(mk(0,1,0,4'h3, 0,0,1, 7));
        tbl.push_back(mk(1,1,0,4'h3, 0,0,1, 7));
        tbl.push_back(mk(0,0,0,4'h3, 0,0,1, 7));

        Resetn = 1'b0; Run = 1'b0; Step = 1'b0; Halt_Req = 1'b0; Opcode_In = 4'h3;
        @(negedge Clock);
        @(negedge Clock);
        check_reset_now();
        Resetn = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset clears the sticky halt without a clock edge.
        #2 Resetn = 1'b0;
        #1 check_reset_now();
        #1 Resetn = 1'b1;

        // Run a NOP stream, then reset asynchronously in mid-stage 3.
        apply(mk(1,0,0,4'h0, 0,0,0, 0));
        apply(mk(1,0,0,4'h0, 1,0,0, 0));
        apply(mk(1,0,0,4'h0, 2,1,0, 0));
        apply(mk(1,0,0,4'h0, 3,1,0, 0));
        apply(mk(1,0,0,4'h0, 4,1,0, 0));
        apply(mk(1,0,0,4'h0, 5,1,0, 0));
        apply(mk(1,0,0,4'h0, 1,0,0, 1));
        apply(mk(1,0,0,4'h0, 2,1,0, 1));
        apply(mk(1,0,0,4'h0, 3,1,0, 1));
        #2 Resetn = 1'b0;
        #1 check_reset_now();
        #1 Resetn = 1'b1;
        apply(mk(1,0,0,4'h3, 1,0,0, 0));

        // Free-run past 16 retirements so the 4-bit counter wraps to 0.
        for (int i = 1; i <= 90; i++)
            apply(mk(1,0,0,4'h3, 3'((i % 5) + 1), 0, 0, 16'(i / 5)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Generates the 3-bit `Stage` code (1=Fetch, 2=Decode, 3=Execute, 4=Memory, 5=WriteBack, 0=idle) and the `NOP_FLAG` consumed by the stage-enable decoder.
- Sits directly upstream of that decoder, between the front-panel/control inputs (`Run`, `Step`, `Halt_Req`) and the datapath enable logic.
- Sequences one instruction at a time through five cycles, supporting free-run, single-step and halt.
- Counts retired instructions.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field presented on `Opcode_In`.
- NOP_OPCODE, 4'b0000, opcode value that marks a no-operation instruction.
- ICOUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Run  input  1  level; 1 = execute instructions continuously.
- Step  input  1  single-cycle pulse; execute exactly one instruction when idle.
- Halt_Req  input  1  pulse or level from the control unit (HALT decoded); stop permanently after the current instruction.
- Opcode_In  input  OPCODE_WIDTH  opcode field of the instruction register; valid from the start of stage 2.
- Stage  output  3  current stage code, 0..5, registered.
- NOP_FLAG  output  1  current instruction is a NOP; qualifies stages 2..5.
- Running  output  1  1 while Stage is nonzero.
- Halted  output  1  sticky halt indicator.
- Instr_Done  output  1  1 during stage 5 of every instruction.
- Instr_Count  output  ICOUNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (Resetn=0, asynchronous, effective immediately, including mid-instruction):
  - Stage=0, mode=IDLE.
  - NOP_FLAG=0, Running=0, Halted=0, Instr_Done=0, Instr_Count=0.
  - Internal halt latch and NOP latch cleared.
- Modes are IDLE, RUN, STEP and HALTED. Stage=0 in IDLE and HALTED.
- IDLE:
  - Run=1 sampled → next edge Stage=1, mode=RUN.
  - Else Step=1 sampled → next edge Stage=1, mode=STEP.
  - Run and Step both 1 → RUN wins.
  - Halt_Req in IDLE → next edge mode=HALTED, Halted=1.
- RUN and STEP stage advance:
  - Stage goes 1→2→3→4→5, one stage per clock, no stalls.
  - At the edge leaving stage 5, Instr_Count increments by 1 and wraps from all-ones to 0.
- End-of-instruction decision, made at the edge leaving stage 5, in priority order:
  1. Halt latch set → Stage=0, mode=HALTED, Halted=1.
  2. mode=RUN and Run=1 → Stage=1 (back-to-back, no idle cycle).
  3. Otherwise → Stage=0, mode=IDLE.
- In STEP mode, Run is ignored until the instruction completes.
- Step pulses arriving while Stage≠0 are ignored; they are not queued.
- Deasserting Run mid-instruction never truncates the instruction; stages 1..5 always complete.
- Halt latch:
  - Set by Halt_Req=1 on any edge while Stage≠0.
  - Cleared only by reset.
- HALTED:
  - Ignores Run and Step.
  - Stage held at 0.
  - Exit only via reset.
- NOP_FLAG:
  - Stage 2: combinational, `(Opcode_In == NOP_OPCODE)`.
  - At the edge leaving stage 2, that value is captured into the NOP latch.
  - Stages 3..5: NOP_FLAG = NOP latch, so later Opcode_In changes have no effect.
  - Stages 0 and 1: NOP_FLAG = 0.
  - NOP instructions still occupy five cycles and still increment Instr_Count.
- Instr_Done = (Stage==5). Running = (Stage≠0). Both are decoded from registered state, with no combinational path from any input.
- Stage never takes the values 6 or 7. If an illegal value is ever reached, the next edge forces Stage=0 and mode=IDLE.

Test Plan:
- Reset then hold Run=1 for 12 cycles → Stage sequence 0,1,2,3,4,5,1,2,3,4,5,1; Instr_Count=2 after the second stage 5; Instr_Done high in exactly two cycles.
- From IDLE, pulse Step once; pulse Step again during stage 3 → Stage 1..5 once, then 0 and stays 0; Instr_Count=1; the second pulse is ignored.
- Run=1, Opcode_In=NOP_OPCODE in stage 2, then change Opcode_In to 4'h3 in stage 3 → NOP_FLAG=1 in stages 2–5 and 0 in stage 1 of the next instruction; the next instruction (opcode 4'h3) shows NOP_FLAG=0.
- Run=1, pulse Halt_Req during stage 2, drop Run in stage 4 → instruction completes to stage 5, then Stage=0, Halted=1, Instr_Count=1; subsequent Run=1 and Step pulses produce no change until reset.
- Run=1, assert Resetn=0 asynchronously mid-stage 3 → Stage=0, NOP_FLAG=0 and Instr_Count=0 without waiting for a clock edge; after release with Run=1, Stage=1 on the next edge.
- Preload by running 65535 instructions with ICOUNT_WIDTH=16 → the 65536th retirement wraps Instr_Count to 0.
